// File: rtl/led_stretch_if.sv
// Signal bundle between an LED activity source and the led_stretch block.
// The master drives activity and lamp test; the slave returns the stretched drive.
interface led_stretch_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] led_in;
    logic             lamp_test;
    logic [WIDTH-1:0] led_out;
    logic             tick;

    modport master (output led_in, output lamp_test, input led_out, input tick);
    modport slave  (input led_in, input lamp_test, output led_out, output tick);
endinterface

// File: rtl/led_stretch.sv
// Per-channel LED pulse stretcher: each activity pulse keeps its LED lit for
// HOLD_TICKS ticks of a shared, free-running millisecond prescaler.
module led_stretch #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE   = 160000,
    parameter int HOLD_TICKS = 50
) (
    input  logic             clock_160,
    input  logic             res,
    input  logic [WIDTH-1:0] led_in,
    input  logic             lamp_test,
    output logic [WIDTH-1:0] led_out,
    output logic             tick
);
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CNT_W = (HOLD_TICKS >= 1) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_TICKS);

    generate
        if (PRESCALE < 1 || HOLD_TICKS < 1) begin : g_bad_param
            $error("led_stretch: PRESCALE and HOLD_TICKS must both be at least 1");
        end
    endgenerate

    logic [PRE_W-1:0] pre_r;
    logic [PRE_W-1:0] pre_nxt_s;
    logic             tick_i_s;
    logic             tick_r;
    logic [CNT_W-1:0] cnt_r     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt_s [WIDTH];
    logic [WIDTH-1:0] led_nxt_s;
    logic [WIDTH-1:0] led_out_r;

    // State register: prescaler, hold counters and the registered outputs.
    always_ff @(posedge clock_160) begin
        if (res) begin
            pre_r     <= '0;
            tick_r    <= 1'b0;
            led_out_r <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            pre_r     <= pre_nxt_s;
            tick_r    <= tick_i_s;
            led_out_r <= led_nxt_s;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Next-state: free-running prescaler; activity reload takes priority over a tick decrement.
    always_comb begin
        tick_i_s = (pre_r == PRE_LAST);
        if (tick_i_s) begin
            pre_nxt_s = '0;
        end else begin
            pre_nxt_s = pre_r + PRE_W'(1);
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (led_in[i]) begin
                cnt_nxt_s[i] = CNT_LOAD;
            end else if (tick_i_s && (cnt_r[i] != '0)) begin
                cnt_nxt_s[i] = cnt_r[i] - CNT_W'(1);
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
        end
    end

    // Output decode: lit while forced, while active, or while the upcoming count is non-zero.
    always_comb begin
        led_nxt_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            led_nxt_s[i] = lamp_test | led_in[i] | (cnt_nxt_s[i] != '0);
        end
    end

    assign led_out = led_out_r;
    assign tick    = tick_r;
endmodule

// File: tb/tb_led_stretch.sv
// Bench for led_stretch: directed scenarios with literal expectations, then
// randomized activity, compared each cycle against an edge-count based model.
module tb_led_stretch;
    localparam int W = 8;
    localparam int P = 4;
    localparam int H = 3;

    logic clock_160 = 1'b0;
    logic res       = 1'b1;

    led_stretch_if #(.WIDTH(W)) bus ();

    led_stretch #(.WIDTH(W), .PRESCALE(P), .HOLD_TICKS(H)) dut (
        .clock_160 (clock_160),
        .res       (res),
        .led_in    (bus.led_in),
        .lamp_test (bus.lamp_test),
        .led_out   (bus.led_out),
        .tick      (bus.tick)
    );

    always #5 clock_160 = ~clock_160;

    int           checks   = 0;
    int           failures = 0;
    logic         chk_en   = 1'b0;
    logic [W-1:0] exp_led  = '0;
    logic         exp_tick = 1'b0;
    int           e_idx    = -1;
    int           last_hi [W];

    // Number of prescaler ticks that have acted at edges 0..x since reset.
    function automatic int ticks_upto(int x);
        return (x + 1) / P;
    endfunction

    // Model: lit while active, or while fewer than H ticks have acted since the last active edge.
    task automatic model_update(input logic r, input logic [W-1:0] din, input logic lt);
        if (r) begin
            e_idx    = -1;
            exp_led  = '0;
            exp_tick = 1'b0;
            for (int i = 0; i < W; i++) last_hi[i] = -1;
        end else begin
            e_idx    = e_idx + 1;
            exp_tick = ((e_idx % P) == P - 1);
            for (int i = 0; i < W; i++) begin
                if (din[i]) last_hi[i] = e_idx;
                if (lt || din[i]) exp_led[i] = 1'b1;
                else if (last_hi[i] >= 0 && (ticks_upto(e_idx) - ticks_upto(last_hi[i])) < H)
                    exp_led[i] = 1'b1;
                else
                    exp_led[i] = 1'b0;
            end
        end
    endtask

    task automatic step(input logic r, input logic [W-1:0] din, input logic lt);
        res           = r;
        bus.led_in    = din;
        bus.lamp_test = lt;
        @(posedge clock_160);
        model_update(r, din, lt);
        chk_en = 1'b1;
        @(negedge clock_160);
    endtask

    task automatic lit(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Compare process: DUT outputs against the model, away from the active edge.
    always @(negedge clock_160) begin
        if (chk_en) begin
            checks++;
            if (bus.led_out !== exp_led) begin
                failures++;
                $display("FAIL led_out at %0t: got %h, expected %h", $time, bus.led_out, exp_led);
            end
            checks++;
            if (bus.tick !== exp_tick) begin
                failures++;
                $display("FAIL tick at %0t: got %b, expected %b", $time, bus.tick, exp_tick);
            end
        end
    end

    initial begin
        logic [W-1:0] din;
        logic         r;
        logic         lt;
        bus.led_in    = '0;
        bus.lamp_test = 1'b0;
        for (int i = 0; i < W; i++) last_hi[i] = -1;

        // Directed scenarios; e is the edge index counted from the first edge after reset.
        for (int s = 0; s < 6; s++) begin
            step(1'b1, 8'h00, 1'b1);
            step(1'b1, 8'hFF, 1'b0);
            lit("reset_led", bus.led_out, 8'h00);
            for (int e = 0; e < 26; e++) begin
                r  = 1'b0;
                din = 8'h00;
                lt = 1'b0;
                case (s)
                    0: if (e == 4) din = 8'h01;
                    1: if (e >= 4 && e <= 8) din = 8'h02;
                    2: if (e == 4 || e == 12) din = 8'h04;
                    3: begin
                        if (e == 4) din = 8'h08;
                        if (e == 9 || e == 10) r = 1'b1;
                    end
                    4: if (e >= 2 && e <= 5) lt = 1'b1;
                    5: if (e == 7) din = 8'hFF;
                    default: din = 8'h00;
                endcase
                step(r, din, lt);
                case (s)
                    0: begin
                        if (e == 4)  lit("s0_pulse_on", bus.led_out, 8'h01);
                        if (e == 14) lit("s0_hold_last", bus.led_out, 8'h01);
                        if (e == 15) lit("s0_off", bus.led_out, 8'h00);
                    end
                    1: begin
                        if (e == 18) lit("s1_hold_last", bus.led_out, 8'h02);
                        if (e == 19) lit("s1_off", bus.led_out, 8'h00);
                    end
                    2: begin
                        if (e == 11) lit("s2_before_repulse", bus.led_out, 8'h04);
                        if (e == 22) lit("s2_hold_last", bus.led_out, 8'h04);
                        if (e == 23) lit("s2_off", bus.led_out, 8'h00);
                    end
                    3: begin
                        if (e == 3)  lit("s3_tick_first", {7'd0, bus.tick}, 8'h01);
                        if (e == 8)  lit("s3_hold", bus.led_out, 8'h08);
                        if (e == 9)  lit("s3_reset_clear", bus.led_out, 8'h00);
                        if (e == 13) lit("s3_tick_quiet", {7'd0, bus.tick}, 8'h00);
                        if (e == 14) lit("s3_tick_back", {7'd0, bus.tick}, 8'h01);
                        if (e == 14) lit("s3_no_residue", bus.led_out, 8'h00);
                    end
                    4: begin
                        if (e == 2) lit("s4_lamp_on", bus.led_out, 8'hFF);
                        if (e == 5) lit("s4_lamp_last", bus.led_out, 8'hFF);
                        if (e == 6) lit("s4_lamp_off", bus.led_out, 8'h00);
                    end
                    5: begin
                        if (e == 18) lit("s5_hold_last", bus.led_out, 8'hFF);
                        if (e == 19) lit("s5_off", bus.led_out, 8'h00);
                    end
                    default: ;
                endcase
            end
        end

        // Randomized activity with occasional lamp test and reset.
        step(1'b1, 8'h00, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 299) == 0);
            lt  = ($urandom_range(0, 49) == 0);
            din = '0;
            for (int i = 0; i < W; i++) din[i] = ($urandom_range(0, 9) == 0);
            if ((n / 200) % 2 == 1) din = din & 8'h0F;
            step(r, din, lt);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
